// File: rtl/lsu_mem_arbiter_if.sv
// lsu_mem_arbiter_if
//   Bundles the load-queue, store-buffer and data_memory signals that meet at
//   the LSU memory arbiter.
//   master : arbiter side (accepts requests, issues responses, drives memory)
//   slave  : environment side (requesters and data_memory)
//   Signals:
//     ld_req_*   load request (valid/ready/addr/byte/tag)
//     ld_resp_*  load response pulse with data/tag/err
//     st_req_*   store request (valid/ready/addr/data/byte/tag)
//     st_done*   store completion pulse with tag/err
//     mem_*      data_memory read and write ports
interface lsu_mem_arbiter_if #(
  parameter int TAG_W = 4
);
  logic             ld_req_valid;
  logic             ld_req_ready;
  logic [31:0]      ld_req_addr;
  logic             ld_req_byte;
  logic [TAG_W-1:0] ld_req_tag;
  logic             ld_resp_valid;
  logic [31:0]      ld_resp_data;
  logic [TAG_W-1:0] ld_resp_tag;
  logic             ld_resp_err;

  logic             st_req_valid;
  logic             st_req_ready;
  logic [31:0]      st_req_addr;
  logic [31:0]      st_req_data;
  logic             st_req_byte;
  logic [TAG_W-1:0] st_req_tag;
  logic             st_done;
  logic [TAG_W-1:0] st_done_tag;
  logic             st_done_err;

  logic             mem_read_enable;
  logic [31:0]      mem_read_address;
  logic             mem_load_byte;
  logic             mem_write_enable;
  logic [31:0]      mem_write_address;
  logic [31:0]      mem_write_value;
  logic             mem_store_byte;
  logic [31:0]      mem_read_value;
  logic             mem_read_valid;
  logic             mem_write_valid;

  modport master (
    input  ld_req_valid, ld_req_addr, ld_req_byte, ld_req_tag,
    output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err,
    input  st_req_valid, st_req_addr, st_req_data, st_req_byte, st_req_tag,
    output st_req_ready, st_done, st_done_tag, st_done_err,
    output mem_read_enable, mem_read_address, mem_load_byte,
    output mem_write_enable, mem_write_address, mem_write_value, mem_store_byte,
    input  mem_read_value, mem_read_valid, mem_write_valid
  );

  modport slave (
    output ld_req_valid, ld_req_addr, ld_req_byte, ld_req_tag,
    input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err,
    output st_req_valid, st_req_addr, st_req_data, st_req_byte, st_req_tag,
    input  st_req_ready, st_done, st_done_tag, st_done_err,
    input  mem_read_enable, mem_read_address, mem_load_byte,
    input  mem_write_enable, mem_write_address, mem_write_value, mem_store_byte,
    output mem_read_value, mem_read_valid, mem_write_valid
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
//   Round-robin arbiter between one load requester and one store requester in
//   front of data_memory, with a single request in flight. Misaligned or
//   out-of-range requests are answered with an error without touching memory;
//   a memory that never answers is cut off after TIMEOUT_CYCLES.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      lsu_mem_arbiter_if.master (requests, responses, memory ports)
//
//   state   | meaning
//   IDLE    | ready for a new request, arbitration active
//   RD_WAIT | read enable held, waiting for mem_read_valid or timeout
//   WR_WAIT | write enable held, waiting for mem_write_valid or timeout
//   ERR_RSP | error response pulse for a rejected request
//   DONE    | response pulse, memory idle for one cycle
module lsu_mem_arbiter #(
  parameter int MEM_SIZE_BYTES = 32,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               clk,
  input logic               reset_n,
  lsu_mem_arbiter_if.master bus
);
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_WAIT, ST_WR_WAIT, ST_ERR_RSP, ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;  // 1 = store was granted last
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             byte_q, byte_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ld_resp_valid_q, ld_resp_valid_d;
  logic             st_done_q, st_done_d;
  logic             resp_err_q, resp_err_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic             grant_ld, grant_st;
  logic [31:0]      req_addr;
  logic             req_byte;
  logic [TAG_W-1:0] req_tag;
  logic [32:0]      req_end;
  logic             req_bad;

  // Load wins a tie when the store went last, and vice versa.
  assign grant_ld = (state_q == ST_IDLE) & bus.ld_req_valid & (~bus.st_req_valid | rr_last_q);
  assign grant_st = (state_q == ST_IDLE) & bus.st_req_valid & (~bus.ld_req_valid | ~rr_last_q);

  assign req_addr = grant_st ? bus.st_req_addr : bus.ld_req_addr;
  assign req_byte = grant_st ? bus.st_req_byte : bus.ld_req_byte;
  assign req_tag  = grant_st ? bus.st_req_tag  : bus.ld_req_tag;
  // 33-bit end address so addresses near 2^32 cannot wrap into range.
  assign req_end  = {1'b0, req_addr} + (req_byte ? 33'd1 : 33'd4);
  assign req_bad  = (~req_byte & (req_addr[1:0] != 2'b00)) | (req_end > 33'(MEM_SIZE_BYTES));

  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    timer_d         = timer_q;
    rd_en_d         = rd_en_q;
    wr_en_d         = wr_en_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    byte_d          = byte_q;
    tag_d           = tag_q;
    ld_resp_valid_d = 1'b0;
    st_done_d       = 1'b0;
    resp_err_d      = resp_err_q;
    resp_data_d     = resp_data_q;
    resp_tag_d      = resp_tag_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ld | grant_st) begin
          rr_last_d = grant_st;
          if (req_bad) begin
            state_d         = ST_ERR_RSP;
            ld_resp_valid_d = grant_ld;
            st_done_d       = grant_st;
            resp_err_d      = 1'b1;
            resp_data_d     = 32'h0;
            resp_tag_d      = req_tag;
          end else begin
            addr_d  = req_addr;
            byte_d  = req_byte;
            tag_d   = req_tag;
            timer_d = TMR_LOAD;
            if (grant_st) begin
              wdata_d = bus.st_req_data;
              wr_en_d = 1'b1;
              state_d = ST_WR_WAIT;
            end else begin
              rd_en_d = 1'b1;
              state_d = ST_RD_WAIT;
            end
          end
        end
      end
      ST_RD_WAIT: begin
        if (bus.mem_read_valid) begin
          rd_en_d         = 1'b0;
          ld_resp_valid_d = 1'b1;
          resp_err_d      = 1'b0;
          resp_tag_d      = tag_q;
          resp_data_d     = byte_q ? {24'h0, bus.mem_read_value[7:0]} : bus.mem_read_value;
          state_d         = ST_DONE;
        end else if (timer_q == '0) begin
          rd_en_d         = 1'b0;
          ld_resp_valid_d = 1'b1;
          resp_err_d      = 1'b1;
          resp_tag_d      = tag_q;
          resp_data_d     = 32'h0;
          state_d         = ST_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (bus.mem_write_valid || (timer_q == '0)) begin
          wr_en_d    = 1'b0;
          st_done_d  = 1'b1;
          resp_err_d = ~bus.mem_write_valid;
          resp_tag_d = tag_q;
          state_d    = ST_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_ERR_RSP: state_d = ST_IDLE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      rr_last_q       <= 1'b1;
      timer_q         <= '0;
      rd_en_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      addr_q          <= 32'h0;
      wdata_q         <= 32'h0;
      byte_q          <= 1'b0;
      tag_q           <= '0;
      ld_resp_valid_q <= 1'b0;
      st_done_q       <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_data_q     <= 32'h0;
      resp_tag_q      <= '0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      timer_q         <= timer_d;
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      byte_q          <= byte_d;
      tag_q           <= tag_d;
      ld_resp_valid_q <= ld_resp_valid_d;
      st_done_q       <= st_done_d;
      resp_err_q      <= resp_err_d;
      resp_data_q     <= resp_data_d;
      resp_tag_q      <= resp_tag_d;
    end
  end

  assign bus.ld_req_ready      = grant_ld;
  assign bus.st_req_ready      = grant_st;
  assign bus.ld_resp_valid     = ld_resp_valid_q;
  assign bus.ld_resp_data      = resp_data_q;
  assign bus.ld_resp_tag       = resp_tag_q;
  assign bus.ld_resp_err       = ld_resp_valid_q & resp_err_q;
  assign bus.st_done           = st_done_q;
  assign bus.st_done_tag       = resp_tag_q;
  assign bus.st_done_err       = st_done_q & resp_err_q;
  assign bus.mem_read_enable   = rd_en_q;
  assign bus.mem_read_address  = addr_q;
  assign bus.mem_load_byte     = byte_q;
  assign bus.mem_write_enable  = wr_en_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_value   = wdata_q;
  assign bus.mem_store_byte    = byte_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
module tb_lsu_mem_arbiter;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  lsu_mem_arbiter_if #(.TAG_W(TAG_W)) bus ();

  lsu_mem_arbiter #(
    .MEM_SIZE_BYTES(32),
    .TAG_W(TAG_W),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [31:0]      data;
  } exp_t;

  exp_t ld_exp_q[$];
  exp_t st_exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_arr [0:31];
  logic [4:0] mem_a;
  int  latency = 2;
  bit  stall_read = 0;
  int  rd_en_cycles = 0, wr_en_cycles = 0;
  int  rd_cnt = 0, wr_cnt = 0;
  int  cyc = 0;
  int  rd_valid_cyc = 0, ld_resp_cyc = 0;
  bit  saw_load_byte = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // data_memory model: answers after `latency` enabled cycles, little-endian.
  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = 8'h00;
    bus.mem_read_valid  = 1'b0;
    bus.mem_write_valid = 1'b0;
    bus.mem_read_value  = 32'h0;
    forever begin
      @(negedge clk);
      bus.mem_read_valid  = 1'b0;
      bus.mem_write_valid = 1'b0;
      if (!reset_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (bus.mem_read_enable) begin
          rd_en_cycles++;
          if (bus.mem_load_byte) saw_load_byte = 1'b1;
          if (!stall_read) begin
            rd_cnt++;
            if (rd_cnt >= latency) begin
              rd_cnt = 0;
              mem_a = bus.mem_read_address[4:0];
              if (bus.mem_load_byte)
                bus.mem_read_value = {24'h0, mem_arr[mem_a]};
              else
                bus.mem_read_value = {mem_arr[mem_a + 5'd3], mem_arr[mem_a + 5'd2],
                                      mem_arr[mem_a + 5'd1], mem_arr[mem_a]};
              bus.mem_read_valid = 1'b1;
              rd_valid_cyc = cyc;
            end
          end
        end
        if (bus.mem_write_enable) begin
          wr_en_cycles++;
          wr_cnt++;
          if (wr_cnt >= latency) begin
            wr_cnt = 0;
            mem_a = bus.mem_write_address[4:0];
            mem_arr[mem_a] = bus.mem_write_value[7:0];
            if (!bus.mem_store_byte) begin
              mem_arr[mem_a + 5'd1] = bus.mem_write_value[15:8];
              mem_arr[mem_a + 5'd2] = bus.mem_write_value[23:16];
              mem_arr[mem_a + 5'd3] = bus.mem_write_value[31:24];
            end
            bus.mem_write_valid = 1'b1;
          end
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n) begin
      checks++;
      if (bus.ld_req_ready && bus.st_req_ready) begin
        failures++;
        $display("FAIL both_ready ld_ready=%0b st_ready=%0b required not both 1", bus.ld_req_ready, bus.st_req_ready);
      end
      if (bus.ld_resp_valid) begin
        ld_resp_cyc = cyc;
        checks++;
        if (ld_exp_q.size() == 0) begin
          failures++;
          $display("FAIL ld_resp_unexpected tag=%0h err=%0b data=%08h required no response", bus.ld_resp_tag, bus.ld_resp_err, bus.ld_resp_data);
        end else begin
          e = ld_exp_q.pop_front();
          if ({bus.ld_resp_tag, bus.ld_resp_err, bus.ld_resp_data} !== {e.tag, e.err, e.data}) begin
            failures++;
            $display("FAIL ld_resp got tag=%0h err=%0b data=%08h required tag=%0h err=%0b data=%08h",
                     bus.ld_resp_tag, bus.ld_resp_err, bus.ld_resp_data, e.tag, e.err, e.data);
          end
        end
      end
      if (bus.st_done) begin
        checks++;
        if (st_exp_q.size() == 0) begin
          failures++;
          $display("FAIL st_done_unexpected tag=%0h err=%0b required no response", bus.st_done_tag, bus.st_done_err);
        end else begin
          e = st_exp_q.pop_front();
          if ({bus.st_done_tag, bus.st_done_err} !== {e.tag, e.err}) begin
            failures++;
            $display("FAIL st_done got tag=%0h err=%0b required tag=%0h err=%0b",
                     bus.st_done_tag, bus.st_done_err, e.tag, e.err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    bus.ld_req_valid = 1'b0;
    bus.st_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input bit is_st, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (is_st ? bus.st_req_ready : bus.ld_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s_accept ready never seen within 200 cycles", name);
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_ld(input logic [31:0] addr, input logic byt, input logic [TAG_W-1:0] tag,
                          input logic err, input logic [31:0] data);
    exp_t e;
    bit ok;
    e.tag = tag; e.err = err; e.data = data;
    ld_exp_q.push_back(e);
    bus.ld_req_addr = addr;
    bus.ld_req_byte = byt;
    bus.ld_req_tag = tag;
    bus.ld_req_valid = 1'b1;
    wait_accept(1'b0, "ld", ok);
    bus.ld_req_valid = 1'b0;
  endtask

  task automatic issue_st(input logic [31:0] addr, input logic [31:0] data, input logic byt,
                          input logic [TAG_W-1:0] tag, input logic err);
    exp_t e;
    bit ok;
    e.tag = tag; e.err = err; e.data = 32'h0;
    st_exp_q.push_back(e);
    bus.st_req_addr = addr;
    bus.st_req_data = data;
    bus.st_req_byte = byt;
    bus.st_req_tag = tag;
    bus.st_req_valid = 1'b1;
    wait_accept(1'b1, "st", ok);
    bus.st_req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((ld_exp_q.size() != 0 || st_exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ld_exp_q.size() != 0 || st_exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending_ld=%0d pending_st=%0d required 0", name, ld_exp_q.size(), st_exp_q.size());
      ld_exp_q.delete();
      st_exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.ld_req_addr = 32'h0; bus.ld_req_byte = 1'b0; bus.ld_req_tag = '0;
    bus.st_req_addr = 32'h0; bus.st_req_data = 32'h0; bus.st_req_byte = 1'b0; bus.st_req_tag = '0;
    reset_n = 1'b0;
    bus.ld_req_valid = 1'b1;
    bus.st_req_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.mem_read_enable, bus.mem_write_enable, bus.ld_resp_valid, bus.st_done,
         bus.ld_resp_err, bus.st_done_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got rd=%0b wr=%0b ldv=%0b std=%0b lde=%0b ste=%0b required all 0",
               bus.mem_read_enable, bus.mem_write_enable, bus.ld_resp_valid, bus.st_done,
               bus.ld_resp_err, bus.st_done_err);
    end
    checks++;
    if ({bus.ld_resp_data, bus.mem_read_address, bus.mem_write_value} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got data=%08h addr=%08h wval=%08h required 0",
               bus.ld_resp_data, bus.mem_read_address, bus.mem_write_value);
    end
    bus.ld_req_valid = 1'b0;
    bus.st_req_valid = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.ld_req_ready, bus.st_req_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready got ld=%0b st=%0b required 0 0 with no valid", bus.ld_req_ready, bus.st_req_ready);
    end
  endtask

  task automatic test_word_store();
    latency = 10;
    wr_en_cycles = 0;
    issue_st(32'h10, 32'hDEADBEEF, 1'b0, 4'h3, 1'b0);
    wait_drain("word_store");
    checks++;
    if (wr_en_cycles != 10) begin
      failures++;
      $display("FAIL word_store_en_cycles got=%0d required=10", wr_en_cycles);
    end
    checks++;
    if ({mem_arr[19], mem_arr[18], mem_arr[17], mem_arr[16]} !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_store_mem got=%08h required=deadbeef",
               {mem_arr[19], mem_arr[18], mem_arr[17], mem_arr[16]});
    end
  endtask

  task automatic test_word_load();
    latency = 3;
    rd_en_cycles = 0;
    issue_ld(32'h10, 1'b0, 4'h5, 1'b0, 32'hDEADBEEF);
    wait_drain("word_load");
    checks++;
    if (ld_resp_cyc - rd_valid_cyc != 1) begin
      failures++;
      $display("FAIL word_load_latency got=%0d required=1", ld_resp_cyc - rd_valid_cyc);
    end
    checks++;
    if (rd_en_cycles != 3) begin
      failures++;
      $display("FAIL word_load_en_cycles got=%0d required=3", rd_en_cycles);
    end
  endtask

  task automatic test_byte_load();
    latency = 2;
    saw_load_byte = 1'b0;
    issue_ld(32'h12, 1'b1, 4'h6, 1'b0, 32'h000000AD);
    wait_drain("byte_load");
    checks++;
    if (saw_load_byte !== 1'b1) begin
      failures++;
      $display("FAIL byte_load_size got=%0b required=1", saw_load_byte);
    end
    // Last legal byte and last legal word are in range.
    issue_ld(32'h1F, 1'b1, 4'hB, 1'b0, 32'h0);
    issue_ld(32'h1C, 1'b0, 4'hC, 1'b0, 32'h0);
    issue_ld(32'h13, 1'b1, 4'hD, 1'b0, 32'h000000DE);
    wait_drain("edge_load");
  endtask

  task automatic test_round_robin();
    logic [TAG_W-1:0] lt = 4'h1;
    logic [TAG_W-1:0] stg = 4'h8;
    logic [31:0] sdata = 32'h10000000;
    bit ok, got_st;
    exp_t e;
    apply_reset();
    latency = 2;
    bus.ld_req_addr = 32'h10; bus.ld_req_byte = 1'b0; bus.ld_req_tag = lt;
    bus.st_req_addr = 32'h08; bus.st_req_byte = 1'b0; bus.st_req_tag = stg; bus.st_req_data = sdata;
    bus.ld_req_valid = 1'b1;
    bus.st_req_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      got_st = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (bus.ld_req_ready || bus.st_req_ready) begin
          ok = 1'b1;
          got_st = bus.st_req_ready;
          break;
        end
      end
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_grant_%0d no grant within 200 cycles", g);
      end else begin
        if (got_st !== (g % 2 == 1)) begin
          failures++;
          $display("FAIL rr_grant_%0d got=%s required=%s", g, got_st ? "S" : "L", (g % 2 == 1) ? "S" : "L");
        end
        if (got_st) begin
          e.tag = stg; e.err = 1'b0; e.data = 32'h0;
          st_exp_q.push_back(e);
        end else begin
          e.tag = lt; e.err = 1'b0; e.data = 32'hDEADBEEF;
          ld_exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      if (got_st) begin
        stg = stg + 1'b1;
        sdata = sdata + 1;
        bus.st_req_tag = stg;
        bus.st_req_data = sdata;
      end else begin
        lt = lt + 1'b1;
        bus.ld_req_tag = lt;
      end
    end
    bus.ld_req_valid = 1'b0;
    bus.st_req_valid = 1'b0;
    wait_drain("round_robin");
  endtask

  task automatic test_errors();
    rd_en_cycles = 0;
    wr_en_cycles = 0;
    issue_ld(32'h11, 1'b0, 4'h7, 1'b1, 32'h0);
    issue_st(32'h1E, 32'h12345678, 1'b0, 4'h8, 1'b1);
    issue_ld(32'h20, 1'b0, 4'h9, 1'b1, 32'h0);
    issue_ld(32'h20, 1'b1, 4'hA, 1'b1, 32'h0);
    issue_st(32'hFFFFFFFC, 32'h1, 1'b0, 4'h2, 1'b1);
    wait_drain("errors");
    checks++;
    if (rd_en_cycles != 0 || wr_en_cycles != 0) begin
      failures++;
      $display("FAIL errors_no_enable got rd=%0d wr=%0d required 0 0", rd_en_cycles, wr_en_cycles);
    end
  endtask

  task automatic test_timeout();
    stall_read = 1'b1;
    rd_en_cycles = 0;
    issue_ld(32'h00, 1'b0, 4'hE, 1'b1, 32'h0);
    wait_drain("timeout");
    checks++;
    if (rd_en_cycles != 64) begin
      failures++;
      $display("FAIL timeout_en_cycles got=%0d required=64", rd_en_cycles);
    end
    stall_read = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    stall_read = 1'b1;
    bus.ld_req_addr = 32'h04; bus.ld_req_byte = 1'b0; bus.ld_req_tag = 4'hF;
    bus.ld_req_valid = 1'b1;
    wait_accept(1'b0, "mid_reset_ld", ok);
    bus.ld_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (bus.mem_read_enable !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_inflight rd_en got=%0b required=1", bus.mem_read_enable);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read_enable, bus.mem_write_enable, bus.ld_resp_valid, bus.st_done} !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got rd=%0b wr=%0b ldv=%0b std=%0b required 0",
               bus.mem_read_enable, bus.mem_write_enable, bus.ld_resp_valid, bus.st_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stall_read = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue_ld(32'h10, 1'b0, 4'h1, 1'b0, 32'hDEADBEEF);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_byte_load();
    test_round_robin();
    test_errors();
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
